// File: rtl/fetch_decode_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Fetches through a single-cycle req/ack port. A word acked while the
// pipeline is stalled is parked in a one-entry skid buffer (HOLD state)
// and delivered to IF/ID once the stall releases.
//
// state | meaning
// FETCH | requesting the word at pc; an ack loads IF/ID or the skid buffer
// HOLD  | skid buffer holds the word for pc; waiting for stall to drop
module fetch_decode_stage #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc,
  output logic        id_valid,
  output logic [31:0] id_instr,
  output logic [31:0] id_pc_plus4,
  output logic [5:0]  id_opcode,
  output logic [4:0]  id_rs,
  output logic [4:0]  id_rt,
  output logic [4:0]  id_rd,
  output logic [15:0] id_imm16
);

  typedef enum logic {FETCH = 1'b0, HOLD = 1'b1} state_t;

  localparam logic [31:0] WORD_MASK = 32'hFFFF_FFFC;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic        id_valid_q, id_valid_d;
  logic [31:0] id_instr_q, id_instr_d;
  logic [31:0] id_pc4_q, id_pc4_d;
  logic [31:0] skid_q, skid_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] pc_plus4;

  assign pc_plus4 = pc_q + 32'd4;

  // Next-state logic; redirect outranks stall and ack in both states.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    id_valid_d = id_valid_q;
    id_instr_d = id_instr_q;
    id_pc4_d   = id_pc4_q;
    skid_d     = skid_q;
    skid_pc4_d = skid_pc4_q;
    imem_req   = (state_q == FETCH);

    if (redirect) begin
      pc_d       = redirect_pc & WORD_MASK;
      id_valid_d = 1'b0;
      id_instr_d = 32'h0;
      skid_d     = 32'h0;
      skid_pc4_d = 32'h0;
      state_d    = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ack && !stall) begin
            id_instr_d = imem_rdata;
            id_pc4_d   = pc_plus4;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4;
          end else if (imem_ack && stall) begin
            skid_d     = imem_rdata;
            skid_pc4_d = pc_plus4;
            state_d    = HOLD;
          end else if (!stall) begin
            id_valid_d = 1'b0;
            id_instr_d = 32'h0;
          end
        end
        HOLD: begin
          if (!stall) begin
            id_instr_d = skid_q;
            id_pc4_d   = skid_pc4_q;
            id_valid_d = 1'b1;
            pc_d       = pc_plus4;
            state_d    = FETCH;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

  // State and pipeline registers with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q    <= FETCH;
      pc_q       <= PC_RESET & WORD_MASK;
      id_valid_q <= 1'b0;
      id_instr_q <= 32'h0;
      id_pc4_q   <= 32'h0;
      skid_q     <= 32'h0;
      skid_pc4_q <= 32'h0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      id_valid_q <= id_valid_d;
      id_instr_q <= id_instr_d;
      id_pc4_q   <= id_pc4_d;
      skid_q     <= skid_d;
      skid_pc4_q <= skid_pc4_d;
    end
  end

  assign pc          = pc_q;
  assign imem_addr   = pc_q;
  assign id_valid    = id_valid_q;
  assign id_instr    = id_instr_q;
  assign id_pc_plus4 = id_pc4_q;
  assign id_opcode   = id_instr_q[31:26];
  assign id_rs       = id_instr_q[25:21];
  assign id_rt       = id_instr_q[20:16];
  assign id_rd       = id_instr_q[15:11];
  assign id_imm16    = id_instr_q[15:0];

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Bench for fetch_decode_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the fetch stage.
module tb_fetch_decode_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] pc;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc_plus4;
  logic [5:0]  id_opcode;
  logic [4:0]  id_rs;
  logic [4:0]  id_rt;
  logic [4:0]  id_rd;
  logic [15:0] id_imm16;

  int errors = 0;
  int checks = 0;
  bit chk_en = 1'b0;

  fetch_decode_stage #(.PC_RESET(32'h0000_0040)) dut (
    .Clk(Clk), .Reset(Reset), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata), .pc(pc),
    .id_valid(id_valid), .id_instr(id_instr), .id_pc_plus4(id_pc_plus4),
    .id_opcode(id_opcode), .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd),
    .id_imm16(id_imm16)
  );

  always #5 Clk = ~Clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Behavioural model: architectural pc, the IF/ID contents, and the
  // parked word (if any) waiting for the stall to release.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_valid;
  logic [31:0] parked_q[$];
  logic [31:0] parked_pc4_q[$];

  always @(posedge Clk) begin
    if (Reset) begin
      m_pc = 32'h40; m_valid = 0; m_instr = 0; m_pc4 = 0;
      parked_q.delete(); parked_pc4_q.delete();
    end else if (redirect) begin
      m_pc = {redirect_pc[31:2], 2'b00};
      m_valid = 0; m_instr = 0;
      parked_q.delete(); parked_pc4_q.delete();
    end else if (parked_q.size() != 0) begin
      if (!stall) begin
        m_instr = parked_q.pop_front();
        m_pc4   = parked_pc4_q.pop_front();
        m_valid = 1;
        m_pc    = m_pc + 4;
      end
    end else if (imem_ack && stall) begin
      parked_q.push_back(imem_rdata);
      parked_pc4_q.push_back(m_pc + 4);
    end else if (imem_ack) begin
      m_instr = imem_rdata; m_pc4 = m_pc + 4; m_valid = 1; m_pc = m_pc + 4;
    end else if (!stall) begin
      m_valid = 0; m_instr = 0;
    end
  end

  // Compare the DUT to the model every cycle, away from the active edge.
  always @(negedge Clk) begin
    if (chk_en) begin
      chk("m_pc",        pc,                  m_pc);
      chk("m_imem_addr", imem_addr,           m_pc);
      chk("m_imem_req",  32'(imem_req),       32'(parked_q.size() == 0));
      chk("m_id_valid",  32'(id_valid),       32'(m_valid));
      chk("m_id_instr",  id_instr,            m_instr);
      chk("m_id_pc4",    id_pc_plus4,         m_pc4);
      chk("m_opcode",    32'(id_opcode),      32'(m_instr >> 26));
      chk("m_rs",        32'(id_rs),          (m_instr >> 21) & 32'h1F);
      chk("m_rt",        32'(id_rt),          (m_instr >> 16) & 32'h1F);
      chk("m_rd",        32'(id_rd),          (m_instr >> 11) & 32'h1F);
      chk("m_imm16",     32'(id_imm16),       m_instr & 32'hFFFF);
    end
  end

  task automatic drive(input bit s, input bit rd, input logic [31:0] rpc,
                       input bit ack, input logic [31:0] rdat);
    stall = s; redirect = rd; redirect_pc = rpc; imem_ack = ack; imem_rdata = rdat;
  endtask

  initial begin
    Reset = 1'b1;
    drive(0, 0, 32'h0, 0, 32'h0);
    repeat (2) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    chk_en = 1'b1;

    // Reset values and first fetch request.
    chk("rst_pc", pc, 32'h40);
    chk("rst_valid", 32'(id_valid), 32'h0);
    chk("rst_instr", id_instr, 32'h0);
    chk("rst_imm16", 32'(id_imm16), 32'h0);
    chk("rst_req", 32'(imem_req), 32'h1);

    // Back-to-back fetches.
    drive(0, 0, 32'h0, 1, 32'h2008_FFFF);
    @(negedge Clk);
    chk("b2b0_instr", id_instr, 32'h2008_FFFF);
    chk("b2b0_imm16", 32'(id_imm16), 32'hFFFF);
    chk("b2b0_pc4", id_pc_plus4, 32'h44);
    chk("b2b0_pc", pc, 32'h44);
    chk("b2b0_opcode", 32'(id_opcode), 32'h08);
    drive(0, 0, 32'h0, 1, 32'h8D09_0004);
    @(negedge Clk);
    chk("b2b1_instr", id_instr, 32'h8D09_0004);
    chk("b2b1_imm16", 32'(id_imm16), 32'h0004);
    chk("b2b1_pc4", id_pc_plus4, 32'h48);
    chk("b2b1_pc", pc, 32'h48);
    chk("b2b1_rs", 32'(id_rs), 32'h08);
    chk("b2b1_rt", 32'(id_rt), 32'h09);

    // Ack under stall parks the word; IF/ID frozen for three cycles.
    drive(1, 0, 32'h0, 1, 32'h1234_5678);
    for (int i = 0; i < 3; i++) begin
      @(negedge Clk);
      chk("stall_instr", id_instr, 32'h8D09_0004);
      chk("stall_req", 32'(imem_req), 32'h0);
      chk("stall_pc", pc, 32'h48);
      drive(1, 0, 32'h0, 0, 32'h0);
    end
    drive(0, 0, 32'h0, 0, 32'h0);
    @(negedge Clk);
    chk("unstall_instr", id_instr, 32'h1234_5678);
    chk("unstall_pc4", id_pc_plus4, 32'h4C);
    chk("unstall_pc", pc, 32'h4C);
    chk("unstall_req", 32'(imem_req), 32'h1);

    // Redirect while holding a parked word.
    drive(1, 0, 32'h0, 1, 32'hDEAD_BEEF);
    @(negedge Clk);
    chk("hold_req", 32'(imem_req), 32'h0);
    drive(1, 1, 32'h0000_0103, 0, 32'h0);
    @(negedge Clk);
    chk("redir_pc", pc, 32'h100);
    chk("redir_valid", 32'(id_valid), 32'h0);
    chk("redir_instr", id_instr, 32'h0);
    chk("redir_req", 32'(imem_req), 32'h1);
    drive(0, 0, 32'h0, 0, 32'h0);
    @(negedge Clk);
    chk("noskid_instr", id_instr, 32'h0);
    chk("noskid_pc", pc, 32'h100);

    // Redirect drops a same-cycle ack.
    drive(0, 1, 32'h0000_0200, 1, 32'hAAAA_5555);
    @(negedge Clk);
    chk("redack_pc", pc, 32'h200);
    chk("redack_valid", 32'(id_valid), 32'h0);
    chk("redack_instr", id_instr, 32'h0);

    // PC wraps modulo 2^32.
    drive(0, 1, 32'hFFFF_FFFF, 0, 32'h0);
    @(negedge Clk);
    chk("wrap_setup_pc", pc, 32'hFFFF_FFFC);
    drive(0, 0, 32'h0, 1, 32'h1111_2222);
    @(negedge Clk);
    chk("wrap_pc", pc, 32'h0);
    chk("wrap_pc4", id_pc_plus4, 32'h0);
    chk("wrap_instr", id_instr, 32'h1111_2222);

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      Reset = ($urandom_range(0, 199) == 0);
      drive($urandom_range(0, 3) == 0, $urandom_range(0, 19) == 0, $urandom,
            $urandom_range(0, 9) < 6, $urandom);
      @(negedge Clk);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
